// File: rtl/issue_queue_multi.sv
// Age-ordered, compacting reservation-station queue with per-FU oldest-ready select,
// multi-port CDB wakeup, enqueue-time CDB bypass and synchronous mispredict flush.
module issue_queue_multi #(
  parameter int ENTRIES   = 8,
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 4,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 16,
  parameter int PAYLOAD_W = 32
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          enq_v_i,
  output logic                          enq_ready_o,
  input  logic [$clog2(NUM_FU)-1:0]     enq_fu_i,
  input  logic [PAYLOAD_W-1:0]          enq_payload_i,
  input  logic [TAG_W-1:0]              enq_src1_tag_i,
  input  logic                          enq_src1_v_i,
  input  logic [DATA_W-1:0]             enq_src1_data_i,
  input  logic [TAG_W-1:0]              enq_src2_tag_i,
  input  logic                          enq_src2_v_i,
  input  logic [DATA_W-1:0]             enq_src2_data_i,
  input  logic [NUM_CDB-1:0]            cdb_v_i,
  input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag_i,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_data_i,
  output logic [NUM_FU-1:0]             iss_v_o,
  input  logic [NUM_FU-1:0]             iss_ready_i,
  output logic [NUM_FU*PAYLOAD_W-1:0]   iss_payload_o,
  output logic [NUM_FU*DATA_W-1:0]      iss_src1_o,
  output logic [NUM_FU*DATA_W-1:0]      iss_src2_o,
  input  logic                          flush_i,
  output logic [$clog2(ENTRIES):0]      count_o
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } src_t;

  typedef struct packed {
    logic [FU_W-1:0]      fu;
    logic [PAYLOAD_W-1:0] payload;
    src_t                 s1;
    src_t                 s2;
  } entry_t;

  entry_t             ent_q   [ENTRIES];
  entry_t             ent_d   [ENTRIES];
  entry_t             woken   [ENTRIES];
  entry_t             new_ent;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ENTRIES-1:0] rdy_vec;
  logic [ENTRIES-1:0] issued;
  logic [ENTRIES-1:0] keep;
  logic [NUM_FU-1:0]  sel_v;
  logic [IDX_W-1:0]   sel_idx [NUM_FU];
  logic [CNT_W-1:0]   pos     [ENTRIES];
  logic [CNT_W-1:0]   survivors;
  logic [CNT_W-1:0]   num_iss;
  logic               enq_fire;

  // Lowest-numbered CDB port wins when several broadcast the same tag.
  function automatic src_t wake(input src_t s,
                                input logic [NUM_CDB-1:0]        cv,
                                input logic [NUM_CDB*TAG_W-1:0]  ct,
                                input logic [NUM_CDB*DATA_W-1:0] cd);
    src_t r;
    logic hit;
    r   = s;
    hit = s.rdy;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (!hit && cv[k] && (ct[k*TAG_W +: TAG_W] == s.tag)) begin
        r.rdy  = 1'b1;
        r.data = cd[k*DATA_W +: DATA_W];
        hit    = 1'b1;
      end
    end
    return r;
  endfunction

  assign enq_ready_o = (count_q < FULL_CNT);
  assign enq_fire    = enq_v_i & enq_ready_o & ~flush_i;
  assign count_o     = count_q;

  // Per-FU select: scanning from the top leaves the lowest (oldest) match.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    for (int f = 0; f < NUM_FU; f++) begin
      sel_v[f]   = 1'b0;
      sel_idx[f] = '0;
    end
    for (int i = 0; i < ENTRIES; i++) begin
      rdy_vec[i] = valid_q[i] & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
    end
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (rdy_vec[i] && (ent_q[i].fu == FU_W'(f))) begin
          sel_v[f]   = 1'b1;
          sel_idx[f] = IDX_W'(i);
        end
      end
    end
  end

  assign iss_v_o = sel_v & {NUM_FU{~flush_i}};

  always_comb begin
    iss_payload_o = '0;
    iss_src1_o    = '0;
    iss_src2_o    = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      iss_payload_o[f*PAYLOAD_W +: PAYLOAD_W] = ent_q[sel_idx[f]].payload;
      iss_src1_o[f*DATA_W +: DATA_W]          = ent_q[sel_idx[f]].s1.data;
      iss_src2_o[f*DATA_W +: DATA_W]          = ent_q[sel_idx[f]].s2.data;
    end
  end

  // An entry has a single target FU, so at most one port can hit each slot.
  always_comb begin
    issued  = '0;
    num_iss = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (iss_v_o[f] && iss_ready_i[f] && (sel_idx[f] == IDX_W'(i))) begin
          issued[i] = 1'b1;
        end
      end
      if (issued[i]) num_iss = num_iss + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      woken[i]    = ent_q[i];
      woken[i].s1 = wake(ent_q[i].s1, cdb_v_i, cdb_tag_i, cdb_data_i);
      woken[i].s2 = wake(ent_q[i].s2, cdb_v_i, cdb_tag_i, cdb_data_i);
    end
    new_ent.fu      = enq_fu_i;
    new_ent.payload = enq_payload_i;
    new_ent.s1      = wake('{tag: enq_src1_tag_i, rdy: enq_src1_v_i, data: enq_src1_data_i},
                           cdb_v_i, cdb_tag_i, cdb_data_i);
    new_ent.s2      = wake('{tag: enq_src2_tag_i, rdy: enq_src2_v_i, data: enq_src2_data_i},
                           cdb_v_i, cdb_tag_i, cdb_data_i);
  end

  // Compaction: survivor i lands in slot pos[i] = number of survivors below it.
  always_comb begin
    keep      = valid_q & ~issued;
    survivors = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pos[i] = survivors;
      if (keep[i]) survivors = survivors + CNT_W'(1);
    end

    for (int j = 0; j < ENTRIES; j++) begin
      ent_d[j]   = ent_q[j];
      valid_d[j] = (CNT_W'(j) < survivors);
      for (int i = j; i < ENTRIES; i++) begin
        if (keep[i] && (pos[i] == CNT_W'(j))) ent_d[j] = woken[i];
      end
      if (enq_fire && (survivors == CNT_W'(j))) begin
        ent_d[j]   = new_ent;
        valid_d[j] = 1'b1;
      end
    end

    count_d = count_q - num_iss + {{(CNT_W-1){1'b0}}, enq_fire};
    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry storage is deliberately left without reset; valid_q
  // qualifies every slot, so its contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < ENTRIES; j++) begin
      ent_q[j] <= ent_d[j];
    end
  end

endmodule

// File: tb/tb_issue_queue_multi.sv
// Directed self-checking bench for issue_queue_multi: issue, wakeup, back-pressure,
// full/issue interaction, enqueue-time bypass, flush and asynchronous reset.
module tb_issue_queue_multi;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enq_v_i;
  logic        enq_ready_o;
  logic [1:0]  enq_fu_i;
  logic [31:0] enq_payload_i;
  logic [5:0]  enq_src1_tag_i, enq_src2_tag_i;
  logic        enq_src1_v_i, enq_src2_v_i;
  logic [15:0] enq_src1_data_i, enq_src2_data_i;
  logic [3:0]  cdb_v_i;
  logic [23:0] cdb_tag_i;
  logic [63:0] cdb_data_i;
  logic [3:0]  iss_v_o;
  logic [3:0]  iss_ready_i;
  logic [127:0] iss_payload_o;
  logic [63:0] iss_src1_o, iss_src2_o;
  logic        flush_i;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  issue_queue_multi dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .enq_v_i         (enq_v_i),
    .enq_ready_o     (enq_ready_o),
    .enq_fu_i        (enq_fu_i),
    .enq_payload_i   (enq_payload_i),
    .enq_src1_tag_i  (enq_src1_tag_i),
    .enq_src1_v_i    (enq_src1_v_i),
    .enq_src1_data_i (enq_src1_data_i),
    .enq_src2_tag_i  (enq_src2_tag_i),
    .enq_src2_v_i    (enq_src2_v_i),
    .enq_src2_data_i (enq_src2_data_i),
    .cdb_v_i         (cdb_v_i),
    .cdb_tag_i       (cdb_tag_i),
    .cdb_data_i      (cdb_data_i),
    .iss_v_o         (iss_v_o),
    .iss_ready_i     (iss_ready_i),
    .iss_payload_o   (iss_payload_o),
    .iss_src1_o      (iss_src1_o),
    .iss_src2_o      (iss_src2_o),
    .flush_i         (flush_i),
    .count_o         (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    enq_v_i         = 1'b0;
    enq_fu_i        = '0;
    enq_payload_i   = '0;
    enq_src1_tag_i  = '0;
    enq_src1_v_i    = 1'b0;
    enq_src1_data_i = '0;
    enq_src2_tag_i  = '0;
    enq_src2_v_i    = 1'b0;
    enq_src2_data_i = '0;
    cdb_v_i         = '0;
    cdb_tag_i       = '0;
    cdb_data_i      = '0;
    flush_i         = 1'b0;
  endtask

  task automatic drive_enq(input logic [1:0] fu, input logic [31:0] pl,
                           input logic [5:0] t1, input logic v1, input logic [15:0] d1,
                           input logic [5:0] t2, input logic v2, input logic [15:0] d2);
    enq_v_i         = 1'b1;
    enq_fu_i        = fu;
    enq_payload_i   = pl;
    enq_src1_tag_i  = t1;
    enq_src1_v_i    = v1;
    enq_src1_data_i = d1;
    enq_src2_tag_i  = t2;
    enq_src2_v_i    = v2;
    enq_src2_data_i = d2;
  endtask

  task automatic drive_cdb(input int k, input logic [5:0] tag, input logic [15:0] data);
    cdb_v_i[k]               = 1'b1;
    cdb_tag_i[k*6 +: 6]      = tag;
    cdb_data_i[k*16 +: 16]   = data;
  endtask

  logic [1:0] fill_fu [8] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
  logic [1:0] five_fu [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    idle();
    iss_ready_i = '0;
    reset_n_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_iss_v", 64'(iss_v_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    reset_n_i = 1'b1;
    tick();

    // Basic enqueue and issue on fu0.
    drive_enq(2'd0, 32'hA000_0001, 6'd1, 1'b1, 16'h1111, 6'd2, 1'b1, 16'h2222);
    tick();
    idle();
    #1;
    check("t1_iss_v", 64'(iss_v_o), 64'b0001);
    check("t1_src1", 64'(iss_src1_o[15:0]), 64'h1111);
    check("t1_src2", 64'(iss_src2_o[15:0]), 64'h2222);
    check("t1_payload", 64'(iss_payload_o[31:0]), 64'hA000_0001);
    check("t1_count1", 64'(count_o), 64'd1);
    iss_ready_i = 4'hF;
    tick();
    iss_ready_i = 4'h0;
    #1;
    check("t1_count0", 64'(count_o), 64'd0);
    check("t1_iss_v_off", 64'(iss_v_o), 64'd0);

    // CDB wakeup on port 2; eligible only the cycle after the broadcast.
    drive_enq(2'd1, 32'hB000_0001, 6'd5, 1'b0, 16'h0000, 6'd3, 1'b1, 16'h0007);
    tick();
    idle();
    #1;
    check("t2_wait_iss_v", 64'(iss_v_o), 64'd0);
    drive_cdb(0, 6'd6, 16'hDEAD);
    drive_cdb(2, 6'd5, 16'h1234);
    #1;
    check("t2_no_bypass", 64'(iss_v_o), 64'd0);
    tick();
    idle();
    #1;
    check("t2_iss_v", 64'(iss_v_o), 64'b0010);
    check("t2_src1", 64'(iss_src1_o[31:16]), 64'h1234);
    check("t2_src2", 64'(iss_src2_o[31:16]), 64'h0007);
    iss_ready_i = 4'hF;
    tick();
    iss_ready_i = 4'h0;
    #1;
    check("t2_count0", 64'(count_o), 64'd0);

    // Back-pressure on fu2: oldest held stable, then issues in order.
    drive_enq(2'd2, 32'hAAAA_0000, 6'd0, 1'b1, 16'h0001, 6'd0, 1'b1, 16'h0002);
    tick();
    drive_enq(2'd2, 32'hBBBB_0000, 6'd0, 1'b1, 16'h0003, 6'd0, 1'b1, 16'h0004);
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_hold_v", 64'(iss_v_o), 64'b0100);
      check("t3_hold_pl", 64'(iss_payload_o[95:64]), 64'hAAAA_0000);
      tick();
    end
    iss_ready_i = 4'b0100;
    #1;
    check("t3_a_pl", 64'(iss_payload_o[95:64]), 64'hAAAA_0000);
    tick();
    #1;
    check("t3_b_v", 64'(iss_v_o), 64'b0100);
    check("t3_b_pl", 64'(iss_payload_o[95:64]), 64'hBBBB_0000);
    check("t3_count1", 64'(count_o), 64'd1);
    tick();
    iss_ready_i = 4'h0;
    #1;
    check("t3_count0", 64'(count_o), 64'd0);
    check("t3_iss_v_off", 64'(iss_v_o), 64'd0);

    // Fill to full, then two issues plus a refused enqueue in one cycle.
    for (int i = 0; i < 8; i++) begin
      check("t4_fill_ready", 64'(enq_ready_o), 64'd1);
      drive_enq(fill_fu[i], 32'hC000_0000 + 32'(i), 6'd0, 1'b1, 16'(i), 6'd0, 1'b1, 16'h0);
      tick();
    end
    idle();
    #1;
    check("t4_full_count", 64'(count_o), 64'd8);
    check("t4_full_ready", 64'(enq_ready_o), 64'd0);
    check("t4_full_iss_v", 64'(iss_v_o), 64'b1011);
    check("t4_fu0_pl", 64'(iss_payload_o[31:0]), 64'hC000_0000);
    check("t4_fu3_pl", 64'(iss_payload_o[127:96]), 64'hC000_0001);
    check("t4_fu1_pl", 64'(iss_payload_o[63:32]), 64'hC000_0002);
    iss_ready_i = 4'b1001;
    drive_enq(2'd2, 32'hDEAD_BEEF, 6'd0, 1'b1, 16'h0, 6'd0, 1'b1, 16'h0);
    #1;
    check("t4_busy_ready", 64'(enq_ready_o), 64'd0);
    tick();
    idle();
    iss_ready_i = 4'b0010;
    #1;
    check("t4_count6", 64'(count_o), 64'd6);
    check("t4_ready_again", 64'(enq_ready_o), 64'd1);
    for (int k = 0; k < 6; k++) begin
      check("t4_drain_v", 64'(iss_v_o), 64'b0010);
      check("t4_drain_pl", 64'(iss_payload_o[63:32]), 64'hC000_0002 + 64'(k));
      tick();
      #1;
    end
    iss_ready_i = 4'h0;
    check("t4_count0", 64'(count_o), 64'd0);

    // Enqueue-time bypass from CDB port 0.
    drive_enq(2'd3, 32'hD000_0001, 6'd1, 1'b1, 16'h0101, 6'd9, 1'b0, 16'h0000);
    drive_cdb(0, 6'd9, 16'hBEEF);
    tick();
    idle();
    #1;
    check("t5_iss_v", 64'(iss_v_o), 64'b1000);
    check("t5_src1", 64'(iss_src1_o[63:48]), 64'h0101);
    check("t5_src2", 64'(iss_src2_o[63:48]), 64'hBEEF);
    iss_ready_i = 4'hF;
    tick();
    iss_ready_i = 4'h0;
    #1;
    check("t5_count0", 64'(count_o), 64'd0);

    // Flush with enqueue and ready FUs pending.
    for (int i = 0; i < 5; i++) begin
      drive_enq(five_fu[i], 32'hE000_0000 + 32'(i), 6'd0, 1'b1, 16'h0, 6'd0, 1'b1, 16'h0);
      tick();
    end
    idle();
    #1;
    check("t6_count5", 64'(count_o), 64'd5);
    check("t6_pre_iss_v", 64'(iss_v_o), 64'b1111);
    flush_i     = 1'b1;
    iss_ready_i = 4'hF;
    drive_enq(2'd1, 32'hFFFF_FFFF, 6'd0, 1'b1, 16'h0, 6'd0, 1'b1, 16'h0);
    #1;
    check("t6_flush_iss_v", 64'(iss_v_o), 64'd0);
    tick();
    idle();
    iss_ready_i = 4'h0;
    #1;
    check("t6_count0", 64'(count_o), 64'd0);
    check("t6_post_iss_v", 64'(iss_v_o), 64'd0);
    check("t6_post_ready", 64'(enq_ready_o), 64'd1);
    drive_enq(2'd2, 32'h0000_0077, 6'd0, 1'b1, 16'h0, 6'd0, 1'b1, 16'h0);
    tick();
    idle();
    #1;
    check("t6_reuse_count", 64'(count_o), 64'd1);
    check("t6_reuse_v", 64'(iss_v_o), 64'b0100);
    check("t6_reuse_pl", 64'(iss_payload_o[95:64]), 64'h0000_0077);
    iss_ready_i = 4'hF;
    tick();
    iss_ready_i = 4'h0;

    // Asynchronous reset in the middle of a cycle.
    drive_enq(2'd0, 32'h1234_5678, 6'd0, 1'b1, 16'h0, 6'd0, 1'b1, 16'h0);
    tick();
    idle();
    #1;
    check("t7_count1", 64'(count_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check("t7_async_count", 64'(count_o), 64'd0);
    check("t7_async_iss_v", 64'(iss_v_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    #1;
    check("t7_ready", 64'(enq_ready_o), 64'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
